// File: rtl/rv_boot_loader.sv
// rv_boot_loader: boot/run controller for the RV32i single-cycle core.
// Streams {channel, addr, data} records into NUM_CH target memories, starts
// the core, waits for its done flag, reads back a result word and reports
// pass / fail / timeout.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined     -> ld_checksum is the wrapping sum of ld_data over all
//                  valid-channel records accepted in the current sequence
//   not defined -> ld_checksum is tied to zero
//
// Handshake: a record transfers on a rising clk edge where ld_valid and
// ld_ready are both high; ld_ready depends only on state, never on
// ld_valid, and the source must hold the record stable until it transfers.
module rv_boot_loader #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int RD_LAT      = 1,
   parameter int RES_CH      = 1,
   parameter int RES_ADDR    = 0,
   parameter int PASS_VAL    = 1,
   parameter int TIMEOUT_CYC = 100000,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [CH_W-1:0]   ld_chan,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [NUM_CH-1:0] mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              core_start,
   input  logic              core_done,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic              bad_chan,
   output logic [15:0]       rec_count,
   output logic [DATA_W-1:0] ld_checksum,
   output logic [2:0]        dbg_state
);

   // Elaboration-time parameter sanity checks.
   if (RES_CH < 0 || RES_CH >= NUM_CH) begin : g_bad_res_ch
      $error("rv_boot_loader: RES_CH must select an existing channel");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("rv_boot_loader: RD_LAT must be 1..4");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_GAP     = 3'd2,
      S_RUN     = 3'd3,
      S_READ    = 3'd4,
      S_WAIT_RD = 3'd5,
      S_CHECK   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [15:0]       rec_q, rec_d;
   logic [31:0]       cyc_q, cyc_d;
   logic [2:0]        lat_q, lat_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              to_q, to_d;
   logic              bad_q, bad_d;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] cs_q, cs_d;
`endif

   logic accept;
   logic chan_ok;

   assign accept  = ld_valid && (state_q == S_LOAD);
   assign chan_ok = (32'(ld_chan) < 32'(NUM_CH));

   // Next-state and datapath updates; every target holds unless a state acts on it.
   always_comb begin
      state_d = state_q;
      we_d    = '0;
      addr_d  = addr_q;
      din_d   = din_q;
      res_d   = res_q;
      rec_d   = rec_q;
      cyc_d   = cyc_q;
      lat_d   = lat_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      to_d    = to_q;
      bad_d   = bad_q;
`ifdef LOADER_CHECKSUM_EN
      cs_d    = cs_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               state_d = S_LOAD;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
               to_d    = 1'b0;
               bad_d   = 1'b0;
               rec_d   = '0;
`ifdef LOADER_CHECKSUM_EN
               cs_d    = '0;
`endif
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (chan_ok) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     we_d[c] = (32'(ld_chan) == c);
                  end
                  addr_d = ld_addr;
                  din_d  = ld_data;
                  if (rec_q != 16'hFFFF) begin
                     rec_d = rec_q + 16'd1;
                  end
`ifdef LOADER_CHECKSUM_EN
                  cs_d = cs_q + ld_data;
`endif
               end else begin
                  // Out-of-range channel: record is consumed but dropped.
                  bad_d = 1'b1;
               end
               if (ld_last) begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Lets the final write land before the core is released.
            state_d = S_RUN;
            cyc_d   = '0;
         end
         S_RUN: begin
            if (core_done) begin
               state_d = S_READ;
            end else if (TIMEOUT_CYC != 0 && cyc_q == 32'(TIMEOUT_CYC - 1)) begin
               to_d    = 1'b1;
               fail_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         S_READ: begin
            state_d = S_WAIT_RD;
            lat_d   = '0;
         end
         S_WAIT_RD: begin
            // Capture lands RD_LAT cycles after the read strobe.
            if (lat_q == 3'(RD_LAT - 1)) begin
               res_d   = mem_dout;
               state_d = S_CHECK;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_CHECK: begin
            pass_d  = (res_q == DATA_W'(PASS_VAL));
            fail_d  = (res_q != DATA_W'(PASS_VAL));
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         res_q   <= '0;
         rec_q   <= '0;
         cyc_q   <= '0;
         lat_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         to_q    <= 1'b0;
         bad_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         cs_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         res_q   <= res_d;
         rec_q   <= rec_d;
         cyc_q   <= cyc_d;
         lat_q   <= lat_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         to_q    <= to_d;
         bad_q   <= bad_d;
`ifdef LOADER_CHECKSUM_EN
         cs_q    <= cs_d;
`endif
      end
   end

   // Output decode; strobes derived from state so reset clears them at once.
   assign ld_ready   = (state_q == S_LOAD);
   assign core_start = (state_q == S_RUN);
   assign mem_re     = (state_q == S_READ);
   assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign mem_we     = we_q;
   assign mem_addr   = (state_q == S_READ) ? ADDR_W'(RES_ADDR) : addr_q;
   assign mem_din    = din_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timeout    = to_q;
   assign bad_chan   = bad_q;
   assign rec_count  = rec_q;
   assign dbg_state  = state_q;
`ifdef LOADER_CHECKSUM_EN
   assign ld_checksum = cs_q;
`else
   assign ld_checksum = '0;
`endif

endmodule

// File: tb/tb_rv_boot_loader.sv
// tb_rv_boot_loader: directed bench for rv_boot_loader (3 channels so that a
// 2-bit ld_chan can carry the out-of-range value 3, RD_LAT=3, timeout 50).
module tb_rv_boot_loader;

   localparam int NUM_CH = 3;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 3;
   localparam int TO_CYC = 50;
   localparam int W      = NUM_CH + ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              go = 1'b0;
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   logic [1:0]        ld_chan = '0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic              ld_last = 1'b0;
   logic [NUM_CH-1:0] mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              core_start;
   logic              core_done = 1'b0;
   logic              busy, pass, fail, timeout, bad_chan;
   logic [15:0]       rec_count;
   logic [DATA_W-1:0] ld_checksum;
   logic [2:0]        dbg_state;

   rv_boot_loader #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
      .RES_CH(1), .RES_ADDR(0), .PASS_VAL(1), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .go(go),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_chan(ld_chan),
      .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .core_start(core_start), .core_done(core_done),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
      .bad_chan(bad_chan), .rec_count(rec_count),
      .ld_checksum(ld_checksum), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- result memory model (RD_LAT pipeline) ----------------
   logic [DATA_W-1:0] res_word = '0;
   logic [2:0]        re_pipe = '0;
   always @(posedge clk) begin
      if (rst) re_pipe <= '0;
      else     re_pipe <= {re_pipe[1:0], mem_re};
   end
   // Only the exact capture cycle carries the real word.
   assign mem_dout = re_pipe[2] ? res_word : 32'hDEAD_BEEF;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   int          last_we_cyc = 0;
   int          exp_rec = 0;
   logic [31:0] exp_cs = '0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Every write pulse must match the next expected record.
   always @(negedge clk) begin
      if (mem_we !== '0) begin
         last_we_cyc = cyc;
         if (exp_q.size() == 0) check("we_extra", 96'(mem_we), 96'(0));
         else check("we_rec", 96'({mem_we, mem_addr, mem_din}), 96'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_go();
      go = 1'b1;
      tick();
      go = 1'b0;
      exp_rec = 0;
      exp_cs  = '0;
      check("go_ready", 96'(ld_ready), 96'(1));
      check("go_busy", 96'(busy), 96'(1));
      check("go_clr_pass", 96'(pass), 96'(0));
      check("go_clr_fail", 96'(fail), 96'(0));
      check("go_clr_to", 96'(timeout), 96'(0));
      check("go_clr_bad", 96'(bad_chan), 96'(0));
      check("go_clr_rec", 96'(rec_count), 96'(0));
   endtask

   task automatic send(input logic [1:0] ch, input logic [31:0] a, input logic [31:0] d,
                       input logic last);
      logic acc;
      logic [NUM_CH-1:0] oh;
      acc = 1'b0;
      ld_valid = 1'b1; ld_chan = ch; ld_addr = a; ld_data = d; ld_last = last;
      for (int k = 0; k < 20; k++) begin
         acc = ld_ready;
         tick();
         if (acc) break;
      end
      if (!acc) check("ld_accept", 96'(0), 96'(1));
      else if (ch < 2'(NUM_CH)) begin
         oh = '0;
         oh[ch] = 1'b1;
         exp_q.push_back({oh, a, d});
         exp_rec++;
         exp_cs = exp_cs + d;
      end
      if (last) begin
         ld_valid = 1'b0;
         ld_last  = 1'b0;
      end
   endtask

   task automatic stall(input int n);
      ld_valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         tick();
         check("stall_ready", 96'(ld_ready), 96'(1));
      end
   endtask

   task automatic check_load_totals(input logic exp_bad);
      check("rec_count", 96'(rec_count), 96'(exp_rec));
      check("bad_chan", 96'(bad_chan), 96'(exp_bad));
`ifdef LOADER_CHECKSUM_EN
      check("checksum", 96'(ld_checksum), 96'(exp_cs));
`else
      check("checksum_off", 96'(ld_checksum), 96'(0));
`endif
   endtask

   task automatic wait_start(output logic found);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (core_start) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      check("start_seen", 96'(found), 96'(1));
      if (found) check("start_after_we", 96'(cyc), 96'(last_we_cyc + 1));
   endtask

   task automatic run_core(input int done_after, input logic [31:0] res, input logic exp_pass);
      logic found;
      logic held;
      res_word = res;
      wait_start(found);
      if (!found) return;
      held = 1'b1;
      for (int k = 1; k < done_after; k++) begin
         tick();
         if (!core_start) held = 1'b0;
      end
      check("start_held", 96'(held), 96'(1));
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("start_drop", 96'(core_start), 96'(0));
      check("re_pulse", 96'(mem_re), 96'(1));
      check("re_addr", 96'(mem_addr), 96'(0));
      tick();
      check("re_one_cycle", 96'(mem_re), 96'(0));
      repeat (3) tick();
      check("busy_in_check", 96'(busy), 96'(1));
      tick();
      check("busy_done", 96'(busy), 96'(0));
      check("pass", 96'(pass), 96'(exp_pass));
      check("fail", 96'(fail), 96'(!exp_pass));
      check("timeout_clear", 96'(timeout), 96'(0));
   endtask

   task automatic load_main();
      send(2'd0, 32'h0000_0000, 32'h0010_0093, 1'b0);
      send(2'd0, 32'h0000_0004, 32'h0020_0113, 1'b0);
      send(2'd0, 32'h0000_0008, 32'h0020_8193, 1'b0);
      send(2'd0, 32'h0000_000C, 32'h0000_8067, 1'b0);
      send(2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0);
      send(2'd1, 32'h0000_0004, 32'h1234_5678, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic found;
      repeat (3) tick();
      check("rst_busy", 96'(busy), 96'(0));
      check("rst_ready", 96'(ld_ready), 96'(0));
      check("rst_start", 96'(core_start), 96'(0));
      check("rst_we", 96'(mem_we), 96'(0));
      check("rst_pass", 96'(pass), 96'(0));
      check("rst_fail", 96'(fail), 96'(0));
      check("rst_rec", 96'(rec_count), 96'(0));
      check("rst_cs", 96'(ld_checksum), 96'(0));
      rst = 1'b0;
      tick();

      // 4 IMEM + 2 DMEM, result 1 -> pass
      start_go();
      load_main();
      check_load_totals(1'b0);
      run_core(20, 32'h0000_0001, 1'b1);

      // re-arm from DONE, result 2 -> fail
      start_go();
      load_main();
      check_load_totals(1'b0);
      run_core(20, 32'h0000_0002, 1'b0);

      // no core_done -> timeout 50 cycles after core_start rises
      start_go();
      send(2'd0, 32'h0000_0000, 32'h0000_006F, 1'b0);
      send(2'd1, 32'h0000_0000, 32'h0000_0001, 1'b1);
      res_word = 32'h0000_0001;
      wait_start(found);
      if (found) begin
         repeat (TO_CYC - 1) tick();
         check("to_pre_start", 96'(core_start), 96'(1));
         check("to_pre_flag", 96'(timeout), 96'(0));
         tick();
         check("to_flag", 96'(timeout), 96'(1));
         check("to_fail", 96'(fail), 96'(1));
         check("to_pass", 96'(pass), 96'(0));
         check("to_start_off", 96'(core_start), 96'(0));
         check("to_busy", 96'(busy), 96'(0));
      end

      // out-of-range channel between valid records, plus a 5-cycle stall
      start_go();
      send(2'd0, 32'h0000_0010, 32'hAAAA_0001, 1'b0);
      stall(5);
      send(2'd3, 32'h0000_0020, 32'hBBBB_0002, 1'b0);
      send(2'd1, 32'h0000_0000, 32'hCCCC_0003, 1'b1);
      check_load_totals(1'b1);
      run_core(7, 32'h0000_0001, 1'b1);

      // reset three cycles into RUN, then a clean reload
      start_go();
      send(2'd0, 32'h0000_0000, 32'h0000_000A, 1'b0);
      send(2'd1, 32'h0000_0000, 32'h0000_0014, 1'b1);
      wait_start(found);
      if (found) begin
         tick();
         tick();
         rst = 1'b1;
         tick();
         check("abort_start", 96'(core_start), 96'(0));
         check("abort_busy", 96'(busy), 96'(0));
         check("abort_re", 96'(mem_re), 96'(0));
         check("abort_we", 96'(mem_we), 96'(0));
         check("abort_rec", 96'(rec_count), 96'(0));
         rst = 1'b0;
         tick();
      end
      start_go();
      send(2'd0, 32'h0000_0000, 32'h0000_0001, 1'b0);
      send(2'd0, 32'h0000_0004, 32'h0000_0002, 1'b0);
      send(2'd1, 32'h0000_0000, 32'h0000_0003, 1'b1);
      check_load_totals(1'b0);
`ifdef LOADER_CHECKSUM_EN
      check("checksum_6", 96'(ld_checksum), 96'(6));
`endif
      run_core(4, 32'h0000_0001, 1'b1);

      repeat (3) tick();
      check("we_missing", 96'(exp_q.size()), 96'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
